// File: rtl/ctrl_decode_queue_pkg.sv
// Shared types for the decode-queue slice.
//  - Opcode, funct3 and funct7 encodings for RV32I and RV32M.
//  - ALU, compare and mux-select enums used by later pipeline stages.
//  - rv32i_ctrl_packet_t, the control word carried from ID to EX.
//  - queue_entry_t, one FIFO slot: control word plus instruction, PC and illegal flag.
package ctrl_decode_queue_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        beq  = 3'b000, bne  = 3'b001, blt  = 3'b100,
        bge  = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        ld_lb = 3'b000, ld_lh = 3'b001, ld_lw = 3'b010,
        ld_lbu = 3'b100, ld_lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        arith_add = 3'b000, arith_sll = 3'b001, arith_slt = 3'b010, arith_sltu = 3'b011,
        arith_xor = 3'b100, arith_sr  = 3'b101, arith_or  = 3'b110, arith_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        md_mul = 3'd0, md_mulh = 3'd1, md_mulhsu = 3'd2, md_mulhu = 3'd3,
        md_div = 3'd4, md_divu = 3'd5, md_rem    = 3'd6, md_remu  = 3'd7
    } muldiv_funct3_t;

    // The encoding of the ALU ops lines up with arith funct3 for add/sll/xor/srl/or/and,
    // so op_imm/op_reg can cast funct3 straight into an aluop.
    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops_t;

    typedef enum logic {a1_rs1_out = 1'b0, a1_pc_out = 1'b1} alumux1_sel_t;

    typedef enum logic [2:0] {
        a2_i_imm = 3'd0, a2_u_imm = 3'd1, a2_b_imm = 3'd2,
        a2_s_imm = 3'd3, a2_j_imm = 3'd4, a2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic {cm_rs2_out = 1'b0, cm_i_imm = 1'b1} cmpmux_sel_t;

    typedef enum logic [3:0] {
        rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw  = 4'd3,
        rf_pc_plus4 = 4'd4, rf_lb  = 4'd5, rf_lbu  = 4'd6, rf_lh  = 4'd7,
        rf_lhu = 4'd8, rf_md_out = 4'd9
    } regfilemux_sel_t;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        alu_ops_t        aluop;
        branch_funct3_t  cmpop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        regfilemux_sel_t regfilemux_sel;
        logic            load_regfile;
        logic            data_mem_read;
        logic            data_mem_write;
        logic [2:0]      mem_funct3;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            md_en;
        muldiv_funct3_t  mdop;
        logic            ex;
        logic            mem;
        logic            wb;
    } rv32i_ctrl_packet_t;

    typedef struct packed {
        rv32i_ctrl_packet_t ctrl;
        logic [31:0]        inst;
        logic [31:0]        pc;
        logic               illegal;
    } queue_entry_t;

endpackage

// File: rtl/ctrl_decode_queue_decoder.sv
// Combinational RV32I (+ optional RV32M) decoder.
//  inst    : 32-bit instruction word
//  ctrl    : decoded control packet (all-zero defaults when illegal)
//  illegal : encoding not supported by this core configuration
module ctrl_decoder
    import ctrl_decode_queue_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [31:0]        inst,
    output rv32i_ctrl_packet_t ctrl,
    output logic               illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];

    // Main decode table. Every path starts from an all-zero packet; any illegal
    // encoding collapses back to that packet at the end so downstream stages see
    // no memory access, no writeback and no stage-enable bits.
    always_comb begin
        logic is_reg;
        ctrl          = '0;
        illegal       = 1'b0;
        is_reg        = (opcode == op_reg);
        ctrl.opcode   = opcode;
        ctrl.rs1_addr = inst[19:15];
        ctrl.rs2_addr = inst[24:20];
        ctrl.rd_addr  = rd;

        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                op_lui: begin
                    ctrl.regfilemux_sel = rf_u_imm;
                    ctrl.load_regfile   = 1'b1;
                    ctrl.ex             = 1'b1;
                    ctrl.wb             = 1'b1;
                end
                op_auipc: begin
                    ctrl.alumux1_sel    = a1_pc_out;
                    ctrl.alumux2_sel    = a2_u_imm;
                    ctrl.regfilemux_sel = rf_alu_out;
                    ctrl.load_regfile   = 1'b1;
                    ctrl.ex             = 1'b1;
                    ctrl.wb             = 1'b1;
                end
                op_jal: begin
                    ctrl.alumux1_sel    = a1_pc_out;
                    ctrl.alumux2_sel    = a2_j_imm;
                    ctrl.regfilemux_sel = rf_pc_plus4;
                    ctrl.load_regfile   = 1'b1;
                    ctrl.is_jal         = 1'b1;
                    ctrl.ex             = 1'b1;
                    ctrl.wb             = 1'b1;
                end
                op_jalr: begin
                    if (funct3 != 3'b000) illegal = 1'b1;
                    ctrl.alumux2_sel    = a2_i_imm;
                    ctrl.regfilemux_sel = rf_pc_plus4;
                    ctrl.load_regfile   = 1'b1;
                    ctrl.is_jalr        = 1'b1;
                    ctrl.ex             = 1'b1;
                    ctrl.wb             = 1'b1;
                end
                op_br: begin
                    if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
                    ctrl.cmpop       = branch_funct3_t'(funct3);
                    ctrl.alumux1_sel = a1_pc_out;
                    ctrl.alumux2_sel = a2_b_imm;
                    ctrl.is_branch   = 1'b1;
                    ctrl.ex          = 1'b1;
                end
                op_load: begin
                    case (funct3)
                        ld_lb:   ctrl.regfilemux_sel = rf_lb;
                        ld_lh:   ctrl.regfilemux_sel = rf_lh;
                        ld_lw:   ctrl.regfilemux_sel = rf_lw;
                        ld_lbu:  ctrl.regfilemux_sel = rf_lbu;
                        ld_lhu:  ctrl.regfilemux_sel = rf_lhu;
                        default: illegal = 1'b1;
                    endcase
                    ctrl.alumux2_sel   = a2_i_imm;
                    ctrl.data_mem_read = 1'b1;
                    ctrl.mem_funct3    = funct3;
                    ctrl.load_regfile  = 1'b1;
                    ctrl.ex            = 1'b1;
                    ctrl.mem           = 1'b1;
                    ctrl.wb            = 1'b1;
                end
                op_store: begin
                    if (funct3 > 3'd2) illegal = 1'b1;
                    ctrl.alumux2_sel    = a2_s_imm;
                    ctrl.data_mem_write = 1'b1;
                    ctrl.mem_funct3     = funct3;
                    ctrl.ex             = 1'b1;
                    ctrl.mem            = 1'b1;
                end
                op_imm, op_reg: begin
                    ctrl.aluop          = alu_ops_t'(funct3);
                    ctrl.regfilemux_sel = rf_alu_out;
                    ctrl.load_regfile   = 1'b1;
                    ctrl.ex             = 1'b1;
                    ctrl.wb             = 1'b1;
                    if (is_reg) begin
                        ctrl.alumux2_sel = a2_rs2_out;
                        ctrl.cmpmux_sel  = cm_rs2_out;
                    end else begin
                        ctrl.alumux2_sel = a2_i_imm;
                        ctrl.cmpmux_sel  = cm_i_imm;
                    end
                    if (is_reg && funct7 == F7_MULDIV) begin
                        if (ENABLE_M != 0) begin
                            ctrl.md_en          = 1'b1;
                            ctrl.mdop           = muldiv_funct3_t'(funct3);
                            ctrl.regfilemux_sel = rf_md_out;
                        end else begin
                            illegal = 1'b1;
                        end
                    end else if (is_reg && funct7 == F7_ALT) begin
                        // Only sub and sra use the alternate funct7 on op_reg.
                        case (funct3)
                            arith_add: ctrl.aluop = alu_sub;
                            arith_sr:  ctrl.aluop = alu_sra;
                            default:   illegal = 1'b1;
                        endcase
                    end else if (is_reg && funct7 != F7_BASE) begin
                        illegal = 1'b1;
                    end else begin
                        // slt/sltu go through the comparator and write br_en;
                        // immediate shifts carry their funct7 in the immediate field.
                        case (funct3)
                            arith_slt: begin
                                ctrl.cmpop          = blt;
                                ctrl.regfilemux_sel = rf_br_en;
                            end
                            arith_sltu: begin
                                ctrl.cmpop          = bltu;
                                ctrl.regfilemux_sel = rf_br_en;
                            end
                            arith_sll: begin
                                if (!is_reg && funct7 != F7_BASE) illegal = 1'b1;
                            end
                            arith_sr: begin
                                if (!is_reg) begin
                                    if (funct7 == F7_ALT)       ctrl.aluop = alu_sra;
                                    else if (funct7 != F7_BASE) illegal = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: illegal = 1'b1;
            endcase
        end

        // Writes to x0 are suppressed here; wb still reflects the instruction class.
        if (illegal)          ctrl = '0;
        else if (rd == 5'd0)  ctrl.load_regfile = 1'b0;
    end

endmodule

// File: rtl/ctrl_decode_queue.sv
// Decode stage with a DEPTH-entry FIFO between IF/ID and ID/EX.
//  clk, rst                    : clock, asynchronous active-high reset
//  flush                       : drop all queued packets at the next edge
//  in_valid/in_ready/in_inst/in_pc          : IF/ID side handshake and payload
//  out_valid/out_ready/out_ctrl/out_inst/out_pc/out_illegal : ID/EX side head packet
//  cnt_decoded/cnt_illegal     : saturating counts of accepted / accepted-illegal instructions
module ctrl_decode_queue
    import ctrl_decode_queue_pkg::*;
#(
    parameter int ENABLE_M = 1,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [31:0]        in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output rv32i_ctrl_packet_t out_ctrl,
    output logic [31:0]        out_inst,
    output logic [31:0]        out_pc,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   cnt_decoded,
    output logic [CNT_W-1:0]   cnt_illegal
);

    localparam int AW = $clog2(DEPTH);

    rv32i_ctrl_packet_t dec_ctrl;
    logic               dec_illegal;
    queue_entry_t       mem [DEPTH];
    queue_entry_t       head;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               push;
    logic               pop;

    ctrl_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_decoder (
        .inst    (in_inst),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // in_ready depends only on occupancy, so a pop in the same cycle as full does
    // not open a slot until the following cycle. A push that coincides with flush
    // is dropped entirely, including from the counters.
    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    assign head        = mem[rd_ptr];
    assign out_ctrl    = head.ctrl;
    assign out_inst    = head.inst;
    assign out_pc      = head.pc;
    assign out_illegal = head.illegal;

    // Storage is cleared on reset so the head outputs read zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{ctrl: dec_ctrl, inst: in_inst, pc: in_pc, illegal: dec_illegal};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count carries the
    // extra bit needed to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    // Performance counters stick at all-ones and survive flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_decoded <= '0;
            cnt_illegal <= '0;
        end else if (push) begin
            if (cnt_decoded != '1)                cnt_decoded <= cnt_decoded + CNT_W'(1);
            if (dec_illegal && cnt_illegal != '1) cnt_illegal <= cnt_illegal + CNT_W'(1);
        end
    end

endmodule
